// File: rtl/data_sram_slave.sv
// rtl/data_sram_slave.sv - EX-stage data SRAM responder with a one-entry posted write buffer
// Reads return one cycle later; buffered store bytes are forwarded so read-after-write stays coherent.
module data_sram_slave #(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        wb_pending
);

  typedef enum logic {WB_EMPTY = 1'b0, WB_FULL = 1'b1} wb_state_e;

  logic [31:0] mem [2**ADDR_W];

  wb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  wb_idx_q, wb_idx_d;
  logic [3:0]         wb_be_q, wb_be_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic               addr_err_q, addr_err_d;

  logic [ADDR_W-1:0]  idx;
  logic               in_range, accept, acc_rd, acc_wr, acc_oor;
  logic               wb_v, same_idx, merge, drain;
  logic [31:0]        rd_word;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^data_sram_addr[1:0];

  assign idx      = data_sram_addr[ADDR_W+1:2];
  assign in_range = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign accept   = data_sram_en && !hold;
  assign acc_rd   = accept && in_range && (data_sram_we == 4'b0000);
  assign acc_wr   = accept && in_range && (data_sram_we != 4'b0000);
  assign acc_oor  = accept && !in_range;

  assign wb_v     = (state_q == WB_FULL);
  assign same_idx = wb_v && (wb_idx_q == idx);
  assign merge    = acc_wr && same_idx;
  // The single array port goes to the read when there is one; otherwise the buffer retires.
  assign drain    = wb_v && !acc_rd && !merge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WB_EMPTY;
      wb_idx_q      <= '0;
      wb_be_q       <= '0;
      wb_data_q     <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wb_idx_q      <= wb_idx_d;
      wb_be_q       <= wb_be_d;
      wb_data_q     <= wb_data_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int k = 0; k < 4; k++) begin
        if (wb_be_q[k]) mem[wb_idx_q][8*k +: 8] <= wb_data_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_EMPTY: if (acc_wr) state_d = WB_FULL;
      WB_FULL:  if (drain && !acc_wr) state_d = WB_EMPTY;
      default:  state_d = WB_EMPTY;
    endcase
  end

  always_comb begin
    wb_idx_d  = wb_idx_q;
    wb_be_d   = wb_be_q;
    wb_data_d = wb_data_q;
    if (acc_wr) begin
      wb_idx_d = idx;
      wb_be_d  = merge ? (wb_be_q | data_sram_we) : data_sram_we;
      for (int k = 0; k < 4; k++) begin
        if (data_sram_we[k]) wb_data_d[8*k +: 8] = data_sram_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[idx];
    if (same_idx) begin
      for (int k = 0; k < 4; k++) begin
        if (wb_be_q[k]) rd_word[8*k +: 8] = wb_data_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;
    addr_err_d    = addr_err_q;
    if (!hold) begin
      rdata_valid_d = acc_rd;
      addr_err_d    = acc_oor;
      if (acc_rd)       rdata_d = rd_word;
      else if (acc_oor) rdata_d = '0;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign addr_err        = addr_err_q;
  assign wb_pending      = wb_v;

endmodule

// File: tb/tb_data_sram_slave.sv
// tb/tb_data_sram_slave.sv - directed self-checking bench for data_sram_slave
module tb_data_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        addr_err;
  logic        wb_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_slave #(.ADDR_W(14), .BASE_ADDR(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hold            (hold),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .rdata_valid     (rdata_valid),
    .addr_err        (addr_err),
    .wb_pending      (wb_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, advance one clock, leave sampling point 1ns after the edge.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic h);
    en = e; we = w; addr = a; wdata = d; hold = h;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
    #12;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_valid", {31'b0, rdata_valid}, 32'h0);
    chk("reset_err",   {31'b0, addr_err}, 32'h0);
    chk("reset_wbp",   {31'b0, wb_pending}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then idle drains, then read from the array
    step(1'b1, 4'hF, 32'h0000_0014, 32'hDEADBEEF, 1'b0);
    chk("t1_wbp_after_wr", {31'b0, wb_pending}, 32'h1);
    idle();
    chk("t1_wbp_after_idle", {31'b0, wb_pending}, 32'h0);
    step(1'b1, 4'h0, 32'h0000_0014, 32'h0, 1'b0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_valid", {31'b0, rdata_valid}, 32'h1);
    idle();
    chk("t1_valid_drop", {31'b0, rdata_valid}, 32'h0);
    chk("t1_rdata_keep", rdata, 32'hDEADBEEF);

    // Partial-lane forwarding
    step(1'b1, 4'hF, 32'h0000_001C, 32'h11223344, 1'b0);
    idle();
    step(1'b1, 4'b0011, 32'h0000_001C, 32'h0000AABB, 1'b0);
    step(1'b1, 4'h0, 32'h0000_001C, 32'h0, 1'b0);
    chk("t2_fwd_rdata", rdata, 32'h1122AABB);
    chk("t2_wbp_held", {31'b0, wb_pending}, 32'h1);
    idle();
    chk("t2_wbp_drained", {31'b0, wb_pending}, 32'h0);
    step(1'b1, 4'h0, 32'h0000_001C, 32'h0, 1'b0);
    chk("t2_array_rdata", rdata, 32'h1122AABB);

    // Merge and replace
    step(1'b1, 4'hF, 32'h0000_000C, 32'h55667788, 1'b0);
    idle();
    step(1'b1, 4'b0001, 32'h0000_000C, 32'h000000AA, 1'b0);
    step(1'b1, 4'b1000, 32'h0000_000C, 32'hBB000000, 1'b0);
    chk("t3_merged_be", {28'b0, dut.wb_be_q}, 32'h9);
    chk("t3_mem3_not_yet", dut.mem[3], 32'h55667788);
    step(1'b1, 4'hF, 32'h0000_0024, 32'h99999999, 1'b0);
    chk("t3_mem3_merged", dut.mem[3], 32'hBB6677AA);
    chk("t3_wbp_replace", {31'b0, wb_pending}, 32'h1);
    step(1'b1, 4'h0, 32'h0000_000C, 32'h0, 1'b0);
    chk("t3_read_merged", rdata, 32'hBB6677AA);
    idle();
    chk("t3_mem9", dut.mem[9], 32'h99999999);

    // Out of range
    step(1'b1, 4'h0, 32'h0001_0000, 32'h0, 1'b0);
    chk("t4_err", {31'b0, addr_err}, 32'h1);
    chk("t4_valid", {31'b0, rdata_valid}, 32'h0);
    chk("t4_rdata", rdata, 32'h0);
    step(1'b1, 4'hF, 32'h0001_0014, 32'h12345678, 1'b0);
    chk("t4_wr_err", {31'b0, addr_err}, 32'h1);
    chk("t4_wbp", {31'b0, wb_pending}, 32'h0);
    idle();
    chk("t4_err_drop", {31'b0, addr_err}, 32'h0);
    chk("t4_mem5", dut.mem[5], 32'hDEADBEEF);

    // Hold freezes outputs while the buffer still drains
    step(1'b1, 4'hF, 32'h0000_0030, 32'hCAFEF00D, 1'b0);
    step(1'b1, 4'h0, 32'h0000_0014, 32'h0, 1'b0);
    chk("t5_rdata", rdata, 32'hDEADBEEF);
    chk("t5_wbp_pre", {31'b0, wb_pending}, 32'h1);
    step(1'b1, 4'h0, 32'h0001_0000, 32'h0, 1'b1);
    chk("t5_wbp_drain_hold", {31'b0, wb_pending}, 32'h0);
    chk("t5_mem12", dut.mem[12], 32'hCAFEF00D);
    step(1'b1, 4'hF, 32'h0000_0050, 32'h0BADF00D, 1'b1);
    chk("t5_wr_ignored", {31'b0, wb_pending}, 32'h0);
    step(1'b1, 4'h0, 32'h0000_001C, 32'h0, 1'b1);
    chk("t5_hold_rdata", rdata, 32'hDEADBEEF);
    chk("t5_hold_valid", {31'b0, rdata_valid}, 32'h1);
    chk("t5_hold_err", {31'b0, addr_err}, 32'h0);
    idle();
    chk("t5_release_valid", {31'b0, rdata_valid}, 32'h0);

    // Asynchronous reset with a pending store
    step(1'b1, 4'hF, 32'h0000_0078, 32'h77777777, 1'b0);
    step(1'b1, 4'h0, 32'h0000_0014, 32'h0, 1'b0);
    chk("t6_pre_valid", {31'b0, rdata_valid}, 32'h1);
    chk("t6_pre_wbp", {31'b0, wb_pending}, 32'h1);
    en = 1'b0; we = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdata", rdata, 32'h0);
    chk("t6_rst_valid", {31'b0, rdata_valid}, 32'h0);
    chk("t6_rst_err", {31'b0, addr_err}, 32'h0);
    chk("t6_rst_wbp", {31'b0, wb_pending}, 32'h0);
    #1;
    rst_n = 1'b1;
    idle();
    chk("t6_post_wbp", {31'b0, wb_pending}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_slave.md
Name: data_sram_slave

Overview:
- Responder end of the EX-stage data SRAM interface (en / we / addr / wdata); returns registered read data to MEM1 one cycle later.
- Holds a single-port data array behind a one-entry posted write buffer.
- Writes retire into the array in cycles when the array port is free.
- Reads that hit the buffered word get buffered bytes forwarded, so read-after-write is always coherent and the block never stalls the pipeline.

Parameters:
- ADDR_W, 14, word-address width; array holds 2^ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000, region base; bits [31:ADDR_W+2] select this block.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; asynchronous, active-low
- hold  in  1  MEM1 freeze; output registers keep their value, request inputs are ignored
- data_sram_en  in  1  request valid
- data_sram_we  in  4  byte-lane write enables; 0 = read
- data_sram_addr  in  32  byte address; bits [1:0] are ignored (lanes already aligned by the LSU)
- data_sram_wdata  in  32  lane-aligned store data
- data_sram_rdata  out  32  read data, registered
- rdata_valid  out  1  pulses the cycle after an accepted in-range read
- addr_err  out  1  pulses the cycle after an accepted out-of-range request
- wb_pending  out  1  write buffer holds an unretired store

Behaviour:
- Reset (async, rst_n=0):
  - data_sram_rdata=0, rdata_valid=0, addr_err=0, wb_pending=0.
  - Write-buffer valid cleared; buffered data discarded.
  - Array contents are not reset.
- Decode:
  - idx = addr[ADDR_W+1:2].
  - in_range = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
  - A request is accepted when en=1 and hold=0.
- Write buffer state: wb_v, wb_idx, wb_be[3:0], wb_data[32]. Two states: EMPTY (wb_v=0) and FULL (wb_v=1); wb_pending = wb_v.
- Array port: exactly one access per cycle, either an array read for an accepted in-range read, or a drain of the buffer (write wb_data lanes wb_be at wb_idx).
- Drain rule:
  - Drain occurs in any cycle with wb_v=1 and no accepted in-range read. This includes hold cycles and idle cycles.
  - If the cycle also accepts a write to the same idx, the merge rule below applies and no drain occurs.
- Accepted in-range write (we≠0):
  - EMPTY: load the buffer (wb_be=we, data lanes), go to FULL.
  - FULL, same idx: merge in place. Lanes with we set are overwritten and wb_be |= we. No drain this cycle.
  - FULL, different idx: the old entry drains to the array and the new entry loads in the same cycle. Stay FULL.
- Accepted in-range read (we=0):
  - Array read at idx.
  - Forwarding: if wb_v and wb_idx==idx, result byte k = wb_be[k] ? wb_data byte k : array byte k. Otherwise the result is the array word.
  - Next cycle: data_sram_rdata=result, rdata_valid=1.
  - The buffer does not drain in this cycle.
- Accepted out-of-range request (read or write):
  - No array or buffer effect.
  - Next cycle: addr_err=1, rdata_valid=0, data_sram_rdata=0.
- Cycles with no accepted request and hold=0: rdata_valid=0 and addr_err=0 next cycle; data_sram_rdata keeps its last value.
- hold=1: data_sram_rdata, rdata_valid and addr_err keep their values; requests are ignored; draining continues.
- Latency: read data 1 cycle. A write is visible to any later read immediately, through forwarding or through the array.
- Reset mid-operation: a buffered store is lost. This is acceptable; reset is a cold start.

Test Plan:
- Read after reset-cleared write: write idx 5 we=4'hF data 32'hDEADBEEF, then one idle cycle, then read idx 5 → rdata=32'hDEADBEEF, rdata_valid=1 exactly one cycle after the read; wb_pending=0 after the idle cycle.
- Forwarding with partial lanes: array[7]=32'h11223344; write idx 7 we=4'b0011 data 32'h0000AABB; read idx 7 the next cycle (no drain possible) → rdata=32'h1122AABB; wb_pending stays 1 until the first non-read cycle.
- Merge and replace:
  - Write idx 3 we=4'b0001 data 32'h000000AA, then idx 3 we=4'b1000 data 32'hBB000000 → wb_be=4'b1001.
  - Then write idx 9 → array[3] byte0=AA, byte3=BB, other bytes unchanged.
  - Read idx 3 → correct merged word.
- Out of range: with ADDR_W=14, read 32'h0001_0000 → addr_err=1 for one cycle, rdata=0, rdata_valid=0; no array change.
- Hold: read idx 5, assert hold for 3 cycles while en=1 with other addresses → rdata and rdata_valid frozen at the idx 5 result; a pending buffer still drains during hold.
- Async reset mid-traffic: pull rst_n low between clock edges with wb_pending=1 → all outputs 0 immediately, without waiting for a clock edge.
